// File: rtl/imm_extend_pipe.sv
// Immediate-extension pipeline: decodes the extension mode from the opcode and
// carries the result through a 1- or 2-stage elastic pipe. Optional branch mode: IMM_BRANCH_SHIFT_EN.
module imm_extend_pipe #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [5:0]        in_opcode,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_mode
);

    localparam logic [1:0] MODE_SIGN   = 2'd0;
    localparam logic [1:0] MODE_ZERO   = 2'd1;
    localparam logic [1:0] MODE_UPPER  = 2'd2;
    localparam logic [1:0] MODE_BRANCH = 2'd3;

    logic [1:0]        w_mode;
    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_ext;
    logic              w_adv1;
    logic              w_s1_dn_rdy;
    logic              w_load1;

    logic              r_v1;
    logic [DATA_W-1:0] r_data1;
    logic [1:0]        r_mode1;

    always_comb begin
        w_mode = MODE_SIGN;
        case (in_opcode)
            6'b001100, 6'b001101, 6'b001110: w_mode = MODE_ZERO;
            6'b001111:                       w_mode = MODE_UPPER;
`ifdef IMM_BRANCH_SHIFT_EN
            6'b000100, 6'b000101:            w_mode = MODE_BRANCH;
`endif
            default:                         w_mode = MODE_SIGN;
        endcase
    end

    assign w_sext = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};

    always_comb begin
        w_ext = w_sext;
        case (w_mode)
            MODE_ZERO:   w_ext = {{(DATA_W-IMM_W){1'b0}}, in_imm};
            MODE_UPPER:  w_ext = {in_imm, {(DATA_W-IMM_W){1'b0}}};
            MODE_BRANCH: w_ext = {w_sext[DATA_W-3:0], 2'b00};
            default:     w_ext = w_sext;
        endcase
    end

    // Flush forces in_ready high so the presented input is consumed and dropped.
    assign w_adv1   = r_v1 & w_s1_dn_rdy;
    assign in_ready = ~r_v1 | w_adv1 | flush;
    assign w_load1  = in_valid & ~flush & (~r_v1 | w_adv1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_data1 <= '0;
            r_mode1 <= MODE_SIGN;
        end else if (flush) begin
            r_v1 <= 1'b0;
        end else if (w_load1) begin
            r_v1    <= 1'b1;
            r_data1 <= w_ext;
            r_mode1 <= w_mode;
        end else if (w_adv1) begin
            r_v1 <= 1'b0;
        end
    end

    generate
        if (DEPTH == 2) begin : g_two
            logic              r_v2;
            logic [DATA_W-1:0] r_data2;
            logic [1:0]        r_mode2;
            logic              w_adv2;

            assign w_adv2      = r_v2 & out_ready;
            assign w_s1_dn_rdy = ~r_v2 | w_adv2;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_v2    <= 1'b0;
                    r_data2 <= '0;
                    r_mode2 <= MODE_SIGN;
                end else if (flush) begin
                    r_v2 <= 1'b0;
                end else if (w_adv1) begin
                    r_v2    <= 1'b1;
                    r_data2 <= r_data1;
                    r_mode2 <= r_mode1;
                end else if (w_adv2) begin
                    r_v2 <= 1'b0;
                end
            end

            assign out_valid = r_v2;
            assign out_data  = r_data2;
            assign out_mode  = r_mode2;
        end else begin : g_one
            assign w_s1_dn_rdy = out_ready;
            assign out_valid   = r_v1;
            assign out_data    = r_data1;
            assign out_mode    = r_mode1;
        end
    endgenerate

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench: a DEPTH=1 and a DEPTH=2 instance driven by hand-computed vectors.
module tb_imm_extend_pipe;

    logic        clk;
    logic        rst_n;

    logic        v1, rdy1, fl1, ov1, ordy1;
    logic [15:0] imm1;
    logic [5:0]  op1;
    logic [31:0] od1;
    logic [1:0]  om1;

    logic        v2, rdy2, fl2, ov2, ordy2;
    logic [15:0] imm2;
    logic [5:0]  op2;
    logic [31:0] od2;
    logic [1:0]  om2;

    int checks = 0;
    int errors = 0;

    imm_extend_pipe #(.DATA_W(32), .IMM_W(16), .DEPTH(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_imm(imm1),
        .in_opcode(op1), .flush(fl1), .out_valid(ov1), .out_ready(ordy1),
        .out_data(od1), .out_mode(om1));

    imm_extend_pipe #(.DATA_W(32), .IMM_W(16), .DEPTH(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2), .in_imm(imm2),
        .in_opcode(op2), .flush(fl2), .out_valid(ov2), .out_ready(ordy2),
        .out_data(od2), .out_mode(om2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        v1 = 0; imm1 = '0; op1 = '0; fl1 = 0; ordy1 = 0;
        v2 = 0; imm2 = '0; op2 = '0; fl2 = 0; ordy2 = 0;
        #2;
        chk("rst_ov1", ov1, 0);
        chk("rst_rdy1", rdy1, 1);
        chk("rst_od1", od1, 0);
        chk("rst_om1", om1, 0);
        chk("rst_ov2", ov2, 0);
        chk("rst_rdy2", rdy2, 1);
        #10 rst_n = 1'b1;
        tick();

        // DEPTH=1 extension modes, one cycle latency
        ordy1 = 1; v1 = 1; imm1 = 16'h8001; op1 = 6'b001000;
        tick();
        chk("sign_ov", ov1, 1);
        chk("sign_data", od1, 32'hFFFF8001);
        chk("sign_mode", om1, 0);
        op1 = 6'b001101;
        tick();
        chk("zero_data", od1, 32'h00008001);
        chk("zero_mode", om1, 1);
        imm1 = 16'h1234; op1 = 6'b001111;
        tick();
        chk("upper_data", od1, 32'h12340000);
        chk("upper_mode", om1, 2);
        imm1 = 16'hFFFF; op1 = 6'b000100;
        tick();
`ifdef IMM_BRANCH_SHIFT_EN
        chk("branch_data", od1, 32'hFFFFFFFC);
        chk("branch_mode", om1, 3);
`else
        chk("branch_data", od1, 32'hFFFFFFFF);
        chk("branch_mode", om1, 0);
`endif
        imm1 = 16'h7FFF; op1 = 6'b001110;
        tick();
        chk("zero_pos_data", od1, 32'h00007FFF);
        v1 = 0;
        tick();
        chk("idle_ov1", ov1, 0);

        // DEPTH=1 stall and hold
        ordy1 = 0; v1 = 1; imm1 = 16'h00FF; op1 = 6'b000000;
        tick();
        chk("stall_ov1", ov1, 1);
        chk("stall_rdy1", rdy1, 0);
        imm1 = 16'h0101; op1 = 6'b001100;
        tick();
        chk("stall_hold1", od1, 32'h000000FF);
        ordy1 = 1;
        #1;
        chk("stall_rel_rdy1", rdy1, 1);
        tick();
        chk("stall_next1", od1, 32'h00000101);
        chk("stall_next_mode1", om1, 1);

        // DEPTH=1 flush drops the pending and the presented input
        ordy1 = 0; imm1 = 16'h0202; op1 = 6'b000000;
        tick();
        fl1 = 1; imm1 = 16'h7777;
        #1;
        chk("flush_rdy1", rdy1, 1);
        tick();
        chk("flush_ov1", ov1, 0);
        fl1 = 0; v1 = 0; ordy1 = 1;
        tick();
        chk("flush_after_ov1", ov1, 0);

        // DEPTH=2 back-to-back, outputs start on the second edge
        ordy2 = 1; op2 = 6'b000000;
        for (int k = 1; k <= 6; k++) begin
            if (k <= 4) begin
                v2 = 1; imm2 = 16'(k);
            end else begin
                v2 = 0;
            end
            tick();
            if (k == 1 || k == 6) begin
                chk("b2b_ov_idle", ov2, 0);
            end else begin
                chk("b2b_ov", ov2, 1);
                chk("b2b_data", od2, 32'(k - 1));
            end
        end

        // DEPTH=2 backpressure: two acceptances then in_ready falls
        ordy2 = 0; v2 = 1; imm2 = 16'h0010;
        tick();
        chk("bp_rdy_a", rdy2, 1);
        imm2 = 16'h0011;
        tick();
        chk("bp_ov", ov2, 1);
        chk("bp_data_a", od2, 32'h00000010);
        chk("bp_rdy_fall", rdy2, 0);
        imm2 = 16'h0012;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold", od2, 32'h00000010);
            chk("bp_rdy_low", rdy2, 0);
        end
        ordy2 = 1; v2 = 0;
        tick();
        chk("bp_drain_b_ov", ov2, 1);
        chk("bp_drain_b", od2, 32'h00000011);
        tick();
        chk("bp_drain_empty", ov2, 0);

        // DEPTH=2 flush with both stages full
        ordy2 = 0; v2 = 1; imm2 = 16'h0020;
        tick();
        imm2 = 16'h0021;
        tick();
        chk("fl2_full_rdy", rdy2, 0);
        fl2 = 1; imm2 = 16'h0022;
        #1;
        chk("fl2_rdy", rdy2, 1);
        tick();
        chk("fl2_ov", ov2, 0);
        fl2 = 0; v2 = 0; ordy2 = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("fl2_no_stale", ov2, 0);
        end
        v2 = 1; imm2 = 16'h0023;
        tick();
        v2 = 0;
        chk("fl2_lat_ov", ov2, 0);
        tick();
        chk("fl2_new_ov", ov2, 1);
        chk("fl2_new_data", od2, 32'h00000023);

        // Reset asserted between edges mid-stream
        v2 = 1; imm2 = 16'h0030;
        tick();
        imm2 = 16'h0031;
        tick();
        chk("rs_pre_data", od2, 32'h00000030);
        imm2 = 16'h0032;
        #2 rst_n = 1'b0;
        #1;
        chk("rs_ov2", ov2, 0);
        chk("rs_od2", od2, 0);
        chk("rs_rdy2", rdy2, 1);
        chk("rs_od1", od1, 0);
        v2 = 0;
        tick();
        #2 rst_n = 1'b1;
        tick();
        chk("rs_after_ov2", ov2, 0);
        v2 = 1; imm2 = 16'h0040;
        tick();
        v2 = 0;
        chk("rs_lat_ov2", ov2, 0);
        tick();
        chk("rs_first_ov2", ov2, 1);
        chk("rs_first_data", od2, 32'h00000040);
        tick();
        chk("rs_end_ov2", ov2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32: output datum width; legal values 32 or 64.
REQ-002 SHALL have parameter IMM_W, default 16: immediate field width; legal values 8 to DATA_W/2.
REQ-003 SHALL have parameter DEPTH, default 1: number of pipeline register stages; legal values 1 or 2.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1: in_imm and in_opcode hold a valid instruction.
REQ-007 SHALL have port in_ready, output, 1: block accepts input this cycle.
REQ-008 SHALL have port in_imm, input, IMM_W: raw immediate field.
REQ-009 SHALL have port in_opcode, input, 6: instruction opcode.
REQ-010 SHALL have port flush, input, 1: discards all in-flight entries.
REQ-011 SHALL have port out_valid, output, 1: out_data and out_mode are valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts output this cycle.
REQ-013 SHALL have port out_data, output, DATA_W: extended immediate.
REQ-014 SHALL have port out_mode, output, 2: mode applied (0 sign, 1 zero, 2 upper, 3 branch).

Function
REQ-015 SHALL decode mode at input: opcodes 001100, 001101 and 001110 select zero; 001111 selects upper; 000100 and 000101 select branch when enabled by REQ-031; all others select sign.
REQ-016 SHALL compute sign mode as in_imm sign-replicated to DATA_W, and zero mode as in_imm zero-padded to DATA_W.
REQ-017 SHALL compute upper mode as in_imm placed in the most significant IMM_W bits, with lower bits zero.
REQ-018 SHALL compute branch mode as the sign-extended value shifted left 2, with the top two bits discarded.
REQ-019 SHALL perform extension combinationally before stage 1 and register both result and mode.
REQ-020 SHALL have latency of exactly DEPTH cycles from accepted input to out_valid with no stall.
REQ-021 SHALL hold one valid bit per stage; a handshake occurs when valid and ready are both 1 in the same cycle.
REQ-022 SHALL let a stage load when it is empty or when its contents move downstream in the same cycle.
REQ-023 SHALL drive in_ready = NOT stage1_valid OR stage1_advances, combinationally; pipeline bubbles collapse.
REQ-024 SHALL hold out_data and out_mode stable while out_valid=1 and out_ready=0.
REQ-025 SHALL sustain throughput of one result per cycle when out_ready is held at 1.
REQ-026 SHALL, on flush=1, clear all valid bits at the next edge and ignore any input presented that cycle; flush takes priority over every handshake.
REQ-027 SHALL drive in_ready=1 during a flush cycle; the input is dropped, not held.

Reset
REQ-028 SHALL, on rst_n low, asynchronously clear all stage valid bits, out_data and out_mode to 0.
REQ-029 SHALL produce out_valid=0 and in_ready=1 while rst_n is low.
REQ-030 SHALL discard in-flight entries on reset mid-operation; the first post-reset result comes only from an input accepted after rst_n rises.

Configuration
REQ-031 SHALL honour macro IMM_BRANCH_SHIFT_EN: when defined, opcodes 000100 and 000101 select branch mode; when undefined, they select sign mode and out_mode never equals 3.

Verification
REQ-032 SHALL pass this scenario: DEPTH=1, in_imm=0x8001 with opcode 001000, then with opcode 001101 -> out_data=0xFFFF8001 mode 0, then 0x00008001 mode 1, each 1 cycle after acceptance.
REQ-033 SHALL pass this scenario: in_imm=0x1234 with opcode 001111 -> out_data=0x12340000 mode 2; with IMM_BRANCH_SHIFT_EN, in_imm=0xFFFF with opcode 000100 -> 0xFFFFFFFC mode 3; without it -> 0xFFFFFFFF mode 0.
REQ-034 SHALL pass this scenario: DEPTH=2, four back-to-back inputs with out_ready=1 -> four outputs on consecutive cycles starting cycle 2, in order.
REQ-035 SHALL pass this scenario: DEPTH=2, out_ready=0 for 5 cycles while in_valid=1 -> in_ready falls after 2 acceptances; out_data is held; releasing out_ready drains both entries in order.
REQ-036 SHALL pass this scenario: flush=1 with both stages full and in_valid=1 -> out_valid=0 next cycle, and no stale or flush-cycle datum ever appears.
REQ-037 SHALL pass this scenario: rst_n low mid-stream between edges -> out_valid=0 and out_data=0 immediately; after rst_n rises, the next output is the next accepted input.
